// File: rtl/lcd8080_seq.sv
// LCD 8080 command/data sequencer: buffers CPU operations in a FIFO and replays
// them to the parallel port one transfer at a time over its start/busy handshake.
module lcd8080_seq #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [1:0]    in_kind,
    input  logic [15:0]   in_payload,
    output logic          in_ready,
    output logic [AW:0]   fifo_level,
    output logic          seq_idle,
    output logic [7:0]    port_cmd,
    output logic [7:0]    port_datain,
    output logic [2:0]    port_func,
    output logic          port_start,
    input  logic          port_busy,
    output logic [15:0]   fill_remaining
);

    localparam logic [1:0] K_CMD    = 2'b00;
    localparam logic [1:0] K_DATA   = 2'b01;
    localparam logic [1:0] K_FILL   = 2'b10;
    localparam logic [1:0] K_SETLEN = 2'b11;

    localparam logic [2:0] FUNC_NONE  = 3'b000;
    localparam logic [2:0] FUNC_CMD   = 3'b001;
    localparam logic [2:0] FUNC_WRITE = 3'b011;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] payload;
    } entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    // FIFO storage and bookkeeping
    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     level_q;
    logic [AW:0]     level_d;
    logic            in_ready_q;
    logic            push;
    logic            pop;
    entry_t          head;

    // Sequencer registers
    state_t          state_q;
    logic [7:0]      port_cmd_q;
    logic [7:0]      port_datain_q;
    logic [2:0]      port_func_q;
    logic            port_start_q;
    logic [15:0]     fill_len_q;
    logic [15:0]     fill_rem_q;
    logic            seq_idle_q;

    assign push = in_valid && in_ready_q;
    assign pop  = (state_q == S_IDLE) && (level_q != '0);
    assign head = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Payload storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry_t'{kind: in_kind, payload: in_payload};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            in_ready_q <= (level_d != (AW+1)'(DEPTH));
        end
    end

    // Transfer sequencer; port_start is registered so it is high exactly while in S_ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            port_cmd_q    <= '0;
            port_datain_q <= '0;
            port_func_q   <= FUNC_NONE;
            port_start_q  <= 1'b0;
            fill_len_q    <= '0;
            fill_rem_q    <= '0;
            seq_idle_q    <= 1'b1;
        end else begin
            port_start_q <= 1'b0;
            seq_idle_q   <= (level_q == '0) && (state_q == S_IDLE) && (fill_rem_q == '0);
            case (state_q)
                S_IDLE: begin
                    port_func_q <= FUNC_NONE;
                    if (pop) begin
                        case (head.kind)
                            K_CMD: begin
                                port_cmd_q   <= head.payload[7:0];
                                port_func_q  <= FUNC_CMD;
                                port_start_q <= 1'b1;
                                state_q      <= S_ISSUE;
                            end
                            K_DATA: begin
                                port_datain_q <= head.payload[7:0];
                                port_func_q   <= FUNC_WRITE;
                                port_start_q  <= 1'b1;
                                state_q       <= S_ISSUE;
                            end
                            K_FILL: begin
                                port_datain_q <= head.payload[7:0];
                                port_func_q   <= FUNC_WRITE;
                                fill_rem_q    <= fill_len_q;
                                if (fill_len_q != '0) begin
                                    port_start_q <= 1'b1;
                                    state_q      <= S_ISSUE;
                                end
                            end
                            K_SETLEN: begin
                                fill_len_q <= head.payload;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (port_busy) begin
                        state_q <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!port_busy) begin
                        if (fill_rem_q > 16'd1) begin
                            // Re-issue the same byte; busy is low here so the port sees a fresh start.
                            fill_rem_q   <= fill_rem_q - 16'd1;
                            port_start_q <= 1'b1;
                            state_q      <= S_ISSUE;
                        end else begin
                            fill_rem_q <= '0;
                            state_q    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_q;
    assign fifo_level     = level_q;
    assign seq_idle       = seq_idle_q;
    assign port_cmd       = port_cmd_q;
    assign port_datain    = port_datain_q;
    assign port_func      = port_func_q;
    assign port_start     = port_start_q;
    assign fill_remaining = fill_rem_q;

endmodule

// File: tb/tb_lcd8080_seq.sv
// Self-checking bench for lcd8080_seq: a busy-handshake port model plus a
// scoreboard of expected port transfers checked on every start pulse.
module tb_lcd8080_seq;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [1:0]    in_kind = 2'b00;
    logic [15:0]   in_payload = 16'h0;
    logic          in_ready;
    logic [AW:0]   fifo_level;
    logic          seq_idle;
    logic [7:0]    port_cmd;
    logic [7:0]    port_datain;
    logic [2:0]    port_func;
    logic          port_start;
    logic          port_busy = 1'b0;
    logic [15:0]   fill_remaining;

    typedef struct {
        logic [2:0] func;
        logic [7:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_starts = 0;
    int   busy_hold = 3;
    int   busy_cnt = 0;
    logic prev_start = 1'b0;

    lcd8080_seq #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_kind        (in_kind),
        .in_payload     (in_payload),
        .in_ready       (in_ready),
        .fifo_level     (fifo_level),
        .seq_idle       (seq_idle),
        .port_cmd       (port_cmd),
        .port_datain    (port_datain),
        .port_func      (port_func),
        .port_start     (port_start),
        .port_busy      (port_busy),
        .fill_remaining (fill_remaining)
    );

    always #5 clk = ~clk;

    // Port model: busy rises the cycle after start and holds for busy_hold cycles.
    always @(posedge clk) begin
        if (port_start) begin
            port_busy <= 1'b1;
            busy_cnt  <= busy_hold;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else begin
            busy_cnt  <= 0;
            port_busy <= 1'b0;
        end
    end

    // Start monitor: every pulse is checked against the scoreboard head.
    always @(negedge clk) begin
        if (port_start) begin
            exp_t e;
            n_starts++;
            checks++;
            if (port_busy !== 1'b0) begin
                errors++;
                $display("FAIL start_while_busy: busy=%b required 0 at t=%0t", port_busy, $time);
            end
            checks++;
            if (prev_start !== 1'b0) begin
                errors++;
                $display("FAIL consecutive_start: previous start=%b required 0 at t=%0t", prev_start, $time);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_start: func=%b cmd=%h data=%h with empty scoreboard", port_func, port_cmd, port_datain);
            end else begin
                e = sb.pop_front();
                checks++;
                if (port_func !== e.func) begin
                    errors++;
                    $display("FAIL start_func: got %b required %b", port_func, e.func);
                end
                checks++;
                if (e.func == 3'b001 && port_cmd !== e.b) begin
                    errors++;
                    $display("FAIL start_cmd: got %h required %h", port_cmd, e.b);
                end else if (e.func == 3'b011 && port_datain !== e.b) begin
                    errors++;
                    $display("FAIL start_data: got %h required %h", port_datain, e.b);
                end
            end
        end
        prev_start = port_start;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic expect_xfer(input logic [2:0] f, input logic [7:0] b);
        exp_t e;
        e.func = f;
        e.b    = b;
        sb.push_back(e);
    endtask

    task automatic push_entry(input logic [1:0] k, input logic [15:0] p);
        in_valid   = 1'b1;
        in_kind    = k;
        in_payload = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && seq_idle === 1'b1 && port_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({in_ready, fifo_level, seq_idle} !== {1'b1, (AW+1)'(0), 1'b1}) begin
            errors++;
            $display("FAIL reset_fifo: ready=%b level=%0d idle=%b required 1/0/1", in_ready, fifo_level, seq_idle);
        end
        checks++;
        if ({port_cmd, port_datain, port_func, port_start} !== 20'h0) begin
            errors++;
            $display("FAIL reset_port: cmd=%h data=%h func=%b start=%b required zeros", port_cmd, port_datain, port_func, port_start);
        end
        checks++;
        if (fill_remaining !== 16'h0) begin
            errors++;
            $display("FAIL reset_fill: got %0d required 0", fill_remaining);
        end
    endtask

    task automatic test_cmd;
        bit ok;
        int n0 = n_starts;
        expect_xfer(3'b001, 8'h2C);
        push_entry(2'b00, 16'h002C);
        checks++;
        if (fifo_level !== (AW+1)'(1)) begin
            errors++;
            $display("FAIL cmd_level_after_push: got %0d required 1", fifo_level);
        end
        @(posedge clk);
        #1;
        checks++;
        if (fifo_level !== (AW+1)'(0)) begin
            errors++;
            $display("FAIL cmd_level_after_pop: got %0d required 0", fifo_level);
        end
        checks++;
        if (port_func !== 3'b001 || port_cmd !== 8'h2C || port_start !== 1'b1) begin
            errors++;
            $display("FAIL cmd_issue: func=%b cmd=%h start=%b required 001/2c/1", port_func, port_cmd, port_start);
        end
        wait_idle(100, ok);
        checks++;
        if (!ok || n_starts != n0 + 1) begin
            errors++;
            $display("FAIL cmd_complete: idle=%b starts=%0d required 1/%0d", ok, n_starts, n0 + 1);
        end
    endtask

    task automatic test_data_stall;
        bit ok = 1'b0;
        int busy_cycles = 0;
        busy_hold = 10;
        expect_xfer(3'b011, 8'hA5);
        push_entry(2'b01, 16'h00A5);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (port_busy === 1'b1) busy_cycles++;
            if (port_func === 3'b011) begin
                checks++;
                if (port_datain !== 8'hA5) begin
                    errors++;
                    $display("FAIL data_stable: got %h required a5 at t=%0t", port_datain, $time);
                end
            end
            if (sb.size() == 0 && seq_idle === 1'b1 && port_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || busy_cycles != 10) begin
            errors++;
            $display("FAIL data_stall: idle=%b busy_cycles=%0d required 1/10", ok, busy_cycles);
        end
        busy_hold = 3;
    endtask

    task automatic test_fill;
        bit ok;
        logic [15:0] seen[$];
        logic [15:0] prev;
        int n0 = n_starts;
        push_entry(2'b11, 16'd5);
        for (int i = 0; i < 5; i++) expect_xfer(3'b011, 8'h3F);
        push_entry(2'b10, 16'h003F);
        prev = fill_remaining;
        for (int i = 0; i < 200 && seen.size() < 6; i++) begin
            @(posedge clk);
            #1;
            if (fill_remaining !== prev) begin
                seen.push_back(fill_remaining);
                prev = fill_remaining;
            end
        end
        checks++;
        if (seen.size() != 6) begin
            errors++;
            $display("FAIL fill_steps: got %0d changes required 6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (seen[i] !== 16'(5 - i)) begin
                    errors++;
                    $display("FAIL fill_count[%0d]: got %0d required %0d", i, seen[i], 5 - i);
                end
            end
        end
        wait_idle(100, ok);
        checks++;
        if (!ok || n_starts != n0 + 5 || fifo_level !== (AW+1)'(0)) begin
            errors++;
            $display("FAIL fill_total: idle=%b starts=%0d level=%0d required 1/%0d/0", ok, n_starts - n0, fifo_level, 5);
        end
    endtask

    task automatic test_fill_zero;
        int n0 = n_starts;
        push_entry(2'b11, 16'd0);
        push_entry(2'b10, 16'h0011);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (n_starts != n0 || seq_idle !== 1'b1 || fill_remaining !== 16'h0 || fifo_level !== (AW+1)'(0)) begin
            errors++;
            $display("FAIL fill_zero: starts=%0d idle=%b rem=%0d level=%0d required 0/1/0/0", n_starts - n0, seq_idle, fill_remaining, fifo_level);
        end
    endtask

    task automatic test_back_to_back;
        bit ok = 1'b0;
        int n0 = n_starts;
        busy_hold = 40;
        expect_xfer(3'b011, 8'h80);
        push_entry(2'b01, 16'h0080);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (port_busy === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL full_busy_rise: busy=%b required 1", port_busy);
        end
        for (int i = 0; i < DEPTH + 2; i++) begin
            logic exp_ready = (i < DEPTH);
            logic [7:0] b = 8'(8'h10 + i);
            in_valid   = 1'b1;
            in_kind    = (i % 2 == 0) ? 2'b00 : 2'b01;
            in_payload = {8'h00, b};
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL full_ready[%0d]: got %b required %b (level=%0d)", i, in_ready, exp_ready, fifo_level);
            end
            if (exp_ready) expect_xfer((i % 2 == 0) ? 3'b001 : 3'b011, b);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (fifo_level !== (AW+1)'(DEPTH) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_level: level=%0d ready=%b required %0d/0", fifo_level, in_ready, DEPTH);
        end
        busy_hold = 2;
        wait_idle(2000, ok);
        checks++;
        if (!ok || n_starts != n0 + DEPTH + 1) begin
            errors++;
            $display("FAIL full_drain: idle=%b starts=%0d required 1/%0d", ok, n_starts - n0, DEPTH + 1);
        end
        busy_hold = 3;
    endtask

    task automatic test_reset_mid_fill;
        bit ok = 1'b0;
        int n0;
        push_entry(2'b11, 16'd6);
        for (int i = 0; i < 6; i++) expect_xfer(3'b011, 8'h77);
        push_entry(2'b10, 16'h0077);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (fill_remaining === 16'd3) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midfill_reach3: rem=%0d required 3", fill_remaining);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        checks++;
        if ({in_ready, fifo_level, seq_idle, port_start, port_func} !== {1'b1, (AW+1)'(0), 1'b1, 1'b0, 3'b000}
            || {port_cmd, port_datain, fill_remaining} !== 32'h0) begin
            errors++;
            $display("FAIL midfill_reset: ready=%b level=%0d idle=%b start=%b func=%b cmd=%h data=%h rem=%0d required reset values",
                     in_ready, fifo_level, seq_idle, port_start, port_func, port_cmd, port_datain, fill_remaining);
        end
        n0 = n_starts;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (n_starts != n0) begin
            errors++;
            $display("FAIL midfill_no_stray: starts=%0d required 0", n_starts - n0);
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (port_busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        expect_xfer(3'b001, 8'h36);
        push_entry(2'b00, 16'h0036);
        wait_idle(100, ok);
        checks++;
        if (!ok || n_starts != n0 + 1) begin
            errors++;
            $display("FAIL midfill_new_entry: idle=%b starts=%0d required 1/1", ok, n_starts - n0);
        end
    endtask

    initial begin
        test_reset();
        test_cmd();
        test_data_stall();
        test_fill();
        test_fill_zero();
        test_back_to_back();
        test_reset_mid_fill();
        repeat (5) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d entries required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
